pipe_run_ctrl: RTL and testbench
================================

Name: pipe_run_ctrl

Overview:
Run/halt/single-step sequencer for the 5-stage RISC-V pipeline. It freezes fetch (PC and IF/ID), injects bubbles into ID/EX, and drains EX/MEM/WB before reporting halted. Halts come from an external request or from an EBREAK/ECALL (opcode 7'h73) decoded in ID. It also keeps cycle and retired-instruction counters for the bench.

Parameters:
DRAIN_CYCLES, 3, cycles of bubble injection after the halt point before halted asserts (EX+MEM+WB).
CNT_W, 32, width of cycle_count and instret_count.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
id_opcode  in  7  opcode of instruction in IF/ID (Curr_Instr[6:0])
id_valid  in  1  IF/ID holds a real (non-flushed, nonzero) instruction
hazard_stall  in  1  load-use stall from hazard detection
flush  in  1  branch/jump redirect (PcSel) this cycle
wb_retire  in  1  valid instruction with RegWrite or store completing WB this cycle
halt_req  in  1  level request to halt
resume_req  in  1  single-cycle pulse, leave HALTED
step_req  in  1  single-cycle pulse, execute one instruction from HALTED
fetch_hold  out  1  freeze PC and IF/ID (ORed with hazard stall at integration)
id_bubble  out  1  force ID/EX to NOP
halted  out  1  pipeline drained and frozen
state  out  3  encoded FSM state for debug
halt_cause  out  2  0 none, 1 request, 2 ebreak, 3 step
cycle_count  out  CNT_W  cycles spent outside HALTED
instret_count  out  CNT_W  wb_retire pulses counted

Behaviour:
- Reset (synchronous, highest priority, also mid-operation):
  - state=RUN, counters=0, halt_cause=0, drain counter=0, ebreak mask=0.
  - fetch_hold=0, id_bubble=0, halted=0.
- States and encoding: RUN=0, DRAIN=1, HALTED=2, STEP_ISSUE=3, STEP_DRAIN=4.
- trap_hit (combinational) = id_valid && id_opcode==7'h73 && !hazard_stall && !flush && !mask.
- RUN:
  - Outputs fetch_hold=0, id_bubble=0, except in the trap_hit cycle, where both are 1 combinationally so the trap never enters EX and PC holds.
  - trap_hit -> DRAIN, cause=2. This takes priority over halt_req.
  - Else halt_req -> DRAIN, cause=1. The request cycle itself still issues normally; hold starts the next cycle.
  - mask clears after one RUN cycle.
- DRAIN / STEP_DRAIN:
  - fetch_hold=1, id_bubble=1.
  - Load counter = DRAIN_CYCLES-1 on entry, decrement each cycle; at 0 -> HALTED.
  - flush during drain has no effect on the counter. Integration gives flush priority over fetch_hold for the PC/IF-ID update, so a branch already in EX still redirects.
  - halt_req, resume_req and step_req are ignored in these states.
- HALTED:
  - halted=1, fetch_hold=1, id_bubble=1.
  - resume_req -> RUN, cause=0. Set mask=1 if the halt was a trap, so the trap still held in IF/ID is consumed as a bubble and not re-detected.
  - Else step_req -> STEP_ISSUE, cause=3. resume_req wins if both pulse in the same cycle.
  - halted deasserts the cycle after the transition.
- STEP_ISSUE:
  - fetch_hold=0, id_bubble=0 for exactly one issuing cycle.
  - If hazard_stall=1, remain in STEP_ISSUE; the datapath stall holds the instruction.
  - If the IF/ID instruction is opcode 7'h73 (ignoring mask): id_bubble=1, fetch_hold=1, cause=2, -> STEP_DRAIN.
  - Otherwise -> STEP_DRAIN after the issue cycle. flush during the issue cycle is allowed.
- Counters:
  - cycle_count increments every cycle state!=HALTED.
  - instret_count increments on wb_retire in any state.
  - Both wrap modulo 2^CNT_W with no saturation.
- Latency:
  - Trap in ID to halted=1 is DRAIN_CYCLES+1 clocks.
  - halt_req to halted=1 is DRAIN_CYCLES+1 clocks.
  - resume_req to fetch_hold=0 is 1 clock.

Test Plan:
1. Program addi x1,x0,5; addi x2,x1,3; ebreak. Required: the ebreak cycle shows id_bubble=1 and fetch_hold=1. halted=1 exactly 4 clocks later, with cause=2, x2=8, instret_count=2, and PC frozen at ebreak+4.
2. halt_req held for 1 cycle during a straight-line addi stream. Required: state goes RUN→DRAIN(3 cycles)→HALTED. Every instruction issued before hold completes, and instret does not change while HALTED.
3. From HALTED after a trap, pulse resume_req. Required: fetch_hold=0 the next cycle, the ebreak is not re-detected (mask), execution continues at the following instruction, and cause=0.
4. From HALTED, pulse step_req three times, each after halted returns. Required: exactly one instruction retires per step (instret +1 each) and cause=3. A step onto a lw→use pair stays in STEP_ISSUE during hazard_stall, then issues.
5. Pulse resume_req and step_req in the same HALTED cycle → RUN. Assert reset during DRAIN → RUN, all outputs 0, counters 0.
6. beq taken in EX at the same cycle halt_req rises. Required: the flush redirects the PC to the target and the drain still completes in 3 cycles. The resume then fetches from the branch target.
7. Preload cycle_count near 2^CNT_W-1 (CNT_W=4 build). Required: it wraps to 0, then counts 1, 2.

Source files
------------

// File: rtl/pipe_run_ctrl.sv
// rtl/pipe_run_ctrl.sv - run/halt/single-step sequencer for the 5-stage pipeline
//
// Freezes fetch, injects ID/EX bubbles and drains EX/MEM/WB before reporting
// halted. Halts come from halt_req or from an EBREAK/ECALL (opcode 7'h73) in ID.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   id_opcode, id_valid instruction currently held in IF/ID
//   hazard_stall, flush load-use stall and branch/jump redirect this cycle
//   wb_retire           an instruction completes WB this cycle
//   halt_req            level halt request
//   resume_req          pulse, HALTED -> RUN
//   step_req            pulse, HALTED -> execute one instruction
//   fetch_hold          freeze PC and IF/ID
//   id_bubble           force ID/EX to NOP
//   halted              pipeline drained and frozen
//   state               encoded FSM state (RUN=0 DRAIN=1 HALTED=2 STEP_ISSUE=3 STEP_DRAIN=4)
//   halt_cause          0 none, 1 request, 2 ebreak, 3 step
//   cycle_count         cycles spent outside HALTED (wraps)
//   instret_count       wb_retire pulses (wraps)

module pipe_run_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       id_opcode,
  input  logic             id_valid,
  input  logic             hazard_stall,
  input  logic             flush,
  input  logic             wb_retire,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic             step_req,
  output logic             fetch_hold,
  output logic             id_bubble,
  output logic             halted,
  output logic [2:0]       state,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  localparam logic [2:0] RUN        = 3'd0;
  localparam logic [2:0] DRAIN      = 3'd1;
  localparam logic [2:0] HALTED     = 3'd2;
  localparam logic [2:0] STEP_ISSUE = 3'd3;
  localparam logic [2:0] STEP_DRAIN = 3'd4;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_REQ   = 2'd1;
  localparam logic [1:0] CAUSE_TRAP  = 2'd2;
  localparam logic [1:0] CAUSE_STEP  = 2'd3;

  localparam int              DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  logic [DW-1:0] drain_cnt;
  logic          mask;
  logic          sys_in_id;
  logic          trap_hit;

  assign sys_in_id = id_valid && (id_opcode == 7'h73);
  // Stalled or flushed IF/ID contents are not really issuing, so they cannot trap.
  // The mask suppresses the trap left in IF/ID after resuming from an ebreak halt.
  assign trap_hit  = sys_in_id && !hazard_stall && !flush && !mask;

  always_comb begin
    fetch_hold = 1'b0;
    id_bubble  = 1'b0;
    halted     = 1'b0;
    case (state)
      RUN: begin
        // Hold the trap in ID in its own detect cycle so it never reaches EX.
        fetch_hold = trap_hit;
        id_bubble  = trap_hit;
      end
      DRAIN, STEP_DRAIN: begin
        fetch_hold = 1'b1;
        id_bubble  = 1'b1;
      end
      HALTED: begin
        fetch_hold = 1'b1;
        id_bubble  = 1'b1;
        halted     = 1'b1;
      end
      STEP_ISSUE: begin
        // Stepping onto a trap does not issue it; the step ends as a trap halt.
        if (!hazard_stall && sys_in_id) begin
          fetch_hold = 1'b1;
          id_bubble  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      halt_cause    <= CAUSE_NONE;
      drain_cnt     <= '0;
      mask          <= 1'b0;
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (state != HALTED)
        cycle_count <= cycle_count + CNT_W'(1);
      if (wb_retire)
        instret_count <= instret_count + CNT_W'(1);

      case (state)
        RUN: begin
          mask <= 1'b0;
          if (trap_hit) begin
            state      <= DRAIN;
            halt_cause <= CAUSE_TRAP;
            drain_cnt  <= DRAIN_LOAD;
          end else if (halt_req) begin
            state      <= DRAIN;
            halt_cause <= CAUSE_REQ;
            drain_cnt  <= DRAIN_LOAD;
          end
        end
        DRAIN, STEP_DRAIN: begin
          if (drain_cnt == '0)
            state <= HALTED;
          else
            drain_cnt <= drain_cnt - DW'(1);
        end
        HALTED: begin
          if (resume_req) begin
            state      <= RUN;
            halt_cause <= CAUSE_NONE;
            mask       <= (halt_cause == CAUSE_TRAP);
          end else if (step_req) begin
            state      <= STEP_ISSUE;
            halt_cause <= CAUSE_STEP;
          end
        end
        STEP_ISSUE: begin
          if (!hazard_stall) begin
            state     <= STEP_DRAIN;
            drain_cnt <= DRAIN_LOAD;
            if (sys_in_id)
              halt_cause <= CAUSE_TRAP;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// tb/tb_pipe_run_ctrl.sv - scoreboard bench for pipe_run_ctrl

module tb_pipe_run_ctrl;

  localparam int CNT_W = 4;

  localparam logic [2:0] R  = 3'd0;
  localparam logic [2:0] D  = 3'd1;
  localparam logic [2:0] H  = 3'd2;
  localparam logic [2:0] SI = 3'd3;
  localparam logic [2:0] SD = 3'd4;

  localparam logic [6:0] OP_ADDI = 7'h13;
  localparam logic [6:0] OP_SYS  = 7'h73;
  localparam logic [6:0] OP_BR   = 7'h63;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       id_opcode;
  logic             id_valid, hazard_stall, flush, wb_retire;
  logic             halt_req, resume_req, step_req;
  logic             fetch_hold, id_bubble, halted;
  logic [2:0]       state;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] cycle_count, instret_count;

  pipe_run_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_opcode(id_opcode), .id_valid(id_valid),
    .hazard_stall(hazard_stall), .flush(flush), .wb_retire(wb_retire),
    .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
    .fetch_hold(fetch_hold), .id_bubble(id_bubble), .halted(halted),
    .state(state), .halt_cause(halt_cause),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic [7:0]       ctrl;   // {fetch_hold, id_bubble, halted, state, halt_cause}
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t             q[$];
  int               total = 0;
  int               bad   = 0;
  int               vec   = 0;
  logic [CNT_W-1:0] exp_cyc = '0;
  logic [CNT_W-1:0] exp_ret = '0;

  // Monitor: every cycle the DUT presents its outputs; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = q.pop_front();
      act = {fetch_hold, id_bubble, halted, state, halt_cause};
      total++;
      if (act !== e.ctrl) begin
        bad++;
        $display("FAIL ctrl vec%0d: got fh/bub/halt/state/cause=%b expected %b", e.id, act, e.ctrl);
      end
      total++;
      if (cycle_count !== e.cyc) begin
        bad++;
        $display("FAIL cycle_count vec%0d: got %0d expected %0d", e.id, cycle_count, e.cyc);
      end
      total++;
      if (instret_count !== e.ret) begin
        bad++;
        $display("FAIL instret_count vec%0d: got %0d expected %0d", e.id, instret_count, e.ret);
      end
    end
  end

  // Apply one cycle of inputs (called #1 after a rising edge) and push expectations.
  task automatic c(input logic [6:0] op, input logic v, hs, fl, wr, hr, rs, sp,
                   input logic [2:0] es, input logic efh, ebb, input logic [1:0] ec);
    exp_t e;
    id_opcode = op; id_valid = v; hazard_stall = hs; flush = fl; wb_retire = wr;
    halt_req = hr; resume_req = rs; step_req = sp;
    e.id   = vec;
    e.ctrl = {efh, ebb, (es == H), es, ec};
    e.cyc  = exp_cyc;
    e.ret  = exp_ret;
    q.push_back(e);
    vec++;
    if (es != H) exp_cyc = exp_cyc + 1'b1;
    if (wr) exp_ret = exp_ret + 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    id_opcode = '0; id_valid = 0; hazard_stall = 0; flush = 0; wb_retire = 0;
    halt_req = 0; resume_req = 0; step_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset   = 1'b0;
    exp_cyc = '0;
    exp_ret = '0;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    // addi; addi; ebreak -> trap halt 4 clocks after detect
    c(OP_ADDI,1,0,0,0,0,0,0, R,0,0,0);
    c(OP_ADDI,1,0,0,0,0,0,0, R,0,0,0);
    c(OP_SYS ,1,0,0,0,0,0,0, R,1,1,0);
    c(OP_SYS ,1,0,0,1,1,1,1, D,1,1,2);   // requests ignored while draining
    c(OP_SYS ,1,0,0,1,0,0,0, D,1,1,2);
    c(OP_SYS ,1,0,0,0,0,0,0, D,1,1,2);
    c(OP_SYS ,1,0,0,0,1,0,0, H,1,1,2);   // halt_req in HALTED ignored
    c(OP_SYS ,1,0,0,0,0,0,0, H,1,1,2);

    // resume after trap: ebreak masked for one cycle, then detected again
    c(OP_SYS ,1,0,0,0,0,1,0, H,1,1,2);
    c(OP_SYS ,1,0,0,0,0,0,0, R,0,0,0);
    c(OP_ADDI,1,0,0,0,0,0,0, R,0,0,0);
    c(OP_SYS ,1,0,0,1,0,0,0, R,1,1,0);
    c(OP_SYS ,1,0,0,0,0,0,0, D,1,1,2);
    c(OP_SYS ,1,0,0,0,0,0,0, D,1,1,2);
    c(OP_SYS ,1,0,0,0,0,0,0, D,1,1,2);
    c(OP_SYS ,1,0,0,0,0,0,0, H,1,1,2);

    // step 1: plain instruction
    c(OP_ADDI,1,0,0,0,0,0,1, H,1,1,2);
    c(OP_ADDI,1,0,0,0,0,0,0, SI,0,0,3);
    c(OP_ADDI,1,0,0,0,0,0,0, SD,1,1,3);
    c(OP_ADDI,1,0,0,0,0,0,0, SD,1,1,3);
    c(OP_ADDI,1,0,0,1,0,1,1, SD,1,1,3);
    c(OP_ADDI,1,0,0,0,0,0,0, H,1,1,3);

    // step 2: load-use stall keeps STEP_ISSUE
    c(OP_ADDI,1,0,0,0,0,0,1, H,1,1,3);
    c(OP_ADDI,1,1,0,0,0,0,0, SI,0,0,3);
    c(OP_ADDI,1,1,0,0,0,0,0, SI,0,0,3);
    c(OP_ADDI,1,0,0,0,0,0,0, SI,0,0,3);
    c(OP_ADDI,1,0,0,0,0,0,0, SD,1,1,3);
    c(OP_ADDI,1,0,0,0,0,0,0, SD,1,1,3);
    c(OP_ADDI,1,0,0,1,0,0,0, SD,1,1,3);
    c(OP_ADDI,1,0,0,0,0,0,0, H,1,1,3);

    // step 3: onto an ebreak -> held, cause becomes trap
    c(OP_SYS ,1,0,0,0,0,0,1, H,1,1,3);
    c(OP_SYS ,1,0,0,0,0,0,0, SI,1,1,3);
    c(OP_SYS ,1,0,0,0,0,0,0, SD,1,1,2);
    c(OP_SYS ,1,0,0,0,0,0,0, SD,1,1,2);
    c(OP_SYS ,1,0,0,0,0,0,0, SD,1,1,2);
    c(OP_SYS ,1,0,0,0,0,0,0, H,1,1,2);

    // resume and step together: resume wins; then reset in the middle of a drain
    c(OP_SYS ,1,0,0,0,0,1,1, H,1,1,2);
    c(OP_SYS ,1,0,0,0,0,0,0, R,0,0,0);
    c(OP_ADDI,1,0,0,1,1,0,0, R,0,0,0);
    c(OP_ADDI,1,0,0,0,0,0,0, D,1,1,1);
    do_reset();
    c(OP_ADDI,1,0,0,0,0,0,0, R,0,0,0);

    // branch flush in the halt_req cycle; drain still 3 cycles
    c(OP_BR  ,1,0,1,0,1,0,0, R,0,0,0);
    c(OP_ADDI,1,0,1,0,0,0,0, D,1,1,1);
    c(OP_ADDI,1,0,0,0,0,0,0, D,1,1,1);
    c(OP_ADDI,1,0,0,0,0,0,0, D,1,1,1);
    c(OP_ADDI,1,0,0,0,0,0,0, H,1,1,1);
    c(OP_ADDI,1,0,0,0,0,1,0, H,1,1,1);
    // request halt leaves no mask: trap qualifiers checked individually
    c(OP_SYS ,1,0,1,0,0,0,0, R,0,0,0);
    c(OP_SYS ,1,1,0,0,0,0,0, R,0,0,0);
    c(OP_SYS ,0,0,0,0,0,0,0, R,0,0,0);

    // long run stream: 4-bit counters wrap through 15 -> 0 -> 1 -> 2
    for (int i = 0; i < 18; i++)
      c(OP_ADDI,1,0,0,i[0],0,0,0, R,0,0,0);
    c(OP_SYS ,1,0,0,0,0,0,0, R,1,1,0);
    c(OP_SYS ,1,0,0,0,0,0,0, D,1,1,2);

    @(negedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
